// File: rtl/regfile_2r1w.sv
// Two-read/one-write register file with registered outputs, write bypass and busy scoreboard.
// Optional macro REGFILE_ZERO_REG_EN hardwires register 0 to zero and makes it unreservable.
`timescale 1ns/1ps
module regfile_2r1w #(
  parameter int DW = 16,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          write,
  input  logic [AW-1:0] writenum,
  input  logic [DW-1:0] data_in,
  input  logic [AW-1:0] readnum_a,
  input  logic [AW-1:0] readnum_b,
  input  logic          rsv,
  input  logic [AW-1:0] rsvnum,
  output logic [DW-1:0] data_out_a,
  output logic [DW-1:0] data_out_b,
  output logic          busy_a,
  output logic          busy_b,
  output logic          rsv_err
);
  localparam int unsigned DEPTH = 2 ** AW;

  logic [DW-1:0]    regs_q [DEPTH];
  logic [DW-1:0]    regs_d [DEPTH];
  logic [DEPTH-1:0] busy_q, busy_d;
  logic [DW-1:0]    data_out_a_q, data_out_a_d;
  logic [DW-1:0]    data_out_b_q, data_out_b_d;
  logic             busy_a_q, busy_a_d;
  logic             busy_b_q, busy_b_d;
  logic             rsv_err_q, rsv_err_d;
  logic             wr_en, rsv_en;

`ifdef REGFILE_ZERO_REG_EN
  assign wr_en  = write && (writenum != '0);
  assign rsv_en = rsv && (rsvnum != '0);
`else
  assign wr_en  = write;
  assign rsv_en = rsv;
`endif

  // Reads index the post-edge image, which yields the bypass and the
  // post-edge busy value; reserve checks busy after the write has cleared it.
  always_comb begin
    regs_d    = regs_q;
    busy_d    = busy_q;
    rsv_err_d = 1'b0;
    if (wr_en) begin
      regs_d[writenum] = data_in;
      busy_d[writenum] = 1'b0;
    end
    if (rsv_en) begin
      rsv_err_d        = busy_d[rsvnum];
      busy_d[rsvnum]   = 1'b1;
    end
    data_out_a_d = regs_d[readnum_a];
    data_out_b_d = regs_d[readnum_b];
    busy_a_d     = busy_d[readnum_a];
    busy_b_d     = busy_d[readnum_b];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      busy_q       <= '0;
      data_out_a_q <= '0;
      data_out_b_q <= '0;
      busy_a_q     <= 1'b0;
      busy_b_q     <= 1'b0;
      rsv_err_q    <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
      busy_q       <= busy_d;
      data_out_a_q <= data_out_a_d;
      data_out_b_q <= data_out_b_d;
      busy_a_q     <= busy_a_d;
      busy_b_q     <= busy_b_d;
      rsv_err_q    <= rsv_err_d;
    end
  end

  assign data_out_a = data_out_a_q;
  assign data_out_b = data_out_b_q;
  assign busy_a     = busy_a_q;
  assign busy_b     = busy_b_q;
  assign rsv_err    = rsv_err_q;
endmodule
